eth_frame_fifo: RTL and testbench
=================================

ETH_FRAME_FIFO -- requirements
Module: eth_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH_WIDTH, default 11, log2 of storage depth in words (4..16).
REQ-003 SHALL have parameter FRAME_MODE, default 1: 0 = stream prefetch FIFO, 1 = store-and-forward frame FIFO.
REQ-004 SHALL have parameter DROP_CNT_WIDTH, default 16, width of the dropped-frame counter.
REQ-005 Ports: clk  in  1  single clock for all logic.
REQ-006 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports: wr_en  in  1  write beat offered; wr_data  in  DATA_WIDTH  write payload; wr_last  in  1  final beat of frame; wr_err  in  1  frame bad, sampled with wr_last.
REQ-008 Ports: wr_vld  out  1  write accept; a beat is taken when wr_en && wr_vld.
REQ-009 Ports: rd_en  in  1  pop request; rd_vld  out  1  rd_data/rd_last valid; rd_data  out  DATA_WIDTH; rd_last  out  1.
REQ-010 Ports: level  out  DEPTH_WIDTH+1  readable words; frame_cnt  out  DEPTH_WIDTH+1  complete frames stored; drop_cnt  out  DROP_CNT_WIDTH  dropped frames.

Function
REQ-011 Storage SHALL be 2^DEPTH_WIDTH words of DATA_WIDTH+1 bits (payload plus last flag), with pointers one bit wider than the address for full/empty.
REQ-012 Read side SHALL be first-word-fall-through: rd_vld=1 means rd_data is the oldest readable word; rd_en && rd_vld pops it; rd_en with rd_vld=0 is ignored.
REQ-013 On pop with further readable data, rd_vld SHALL stay 1 and the next word SHALL present on the following cycle (full throughput, one word per clock).
REQ-014 rd_vld SHALL first rise at the second clock edge after the edge that makes a word readable into an empty FIFO.
REQ-015 FRAME_MODE=0: every accepted beat SHALL become readable immediately; wr_vld = not full; wr_last stored, wr_err ignored.
REQ-016 FRAME_MODE=1: beats SHALL be written at a speculative pointer; reader SHALL see only words up to the committed pointer.
REQ-017 FRAME_MODE=1 write FSM states: IDLE (no frame open), FILL (frame open), DROP (discarding frame).
REQ-018 IDLE->FILL on an accepted beat with wr_last=0; a single-beat frame (wr_last=1) commits or drops directly, staying in IDLE.
REQ-019 On accepted wr_last with wr_err=0, committed pointer SHALL take the post-write speculative value on the same edge; frame_cnt increments; FSM->IDLE.
REQ-020 On accepted wr_last with wr_err=1, speculative pointer SHALL rewind to committed pointer; drop_cnt increments (saturating); FSM->IDLE.
REQ-021 FRAME_MODE=1: wr_vld SHALL be constant 1; a beat arriving when full SHALL NOT be stored, FSM->DROP, speculative pointer rewinds.
REQ-022 In DROP all beats SHALL be discarded; on wr_last FSM->IDLE and drop_cnt increments once, regardless of wr_err.
REQ-023 frame_cnt SHALL decrement when a word with last flag pops; simultaneous commit and last-pop SHALL leave it unchanged.
REQ-024 level SHALL equal committed minus read pointer including the output-register word; simultaneous write-commit and pop SHALL net correctly.
REQ-025 Pointers SHALL wrap modulo 2^(DEPTH_WIDTH+1); full = MSBs differ and address bits equal.

Reset
REQ-026 While rst_n=0: all pointers, counters, level, frame_cnt, drop_cnt = 0; rd_vld=0; rd_data=0; rd_last=0; FSM=IDLE; wr_vld=1 (FRAME_MODE=1) or 1 after release (FRAME_MODE=0).
REQ-027 Reset mid-frame SHALL discard the open frame without counting it in drop_cnt; memory contents need not clear.

Structure
REQ-028 Package eth_fifo_pkg SHALL hold the write FSM state encoding and the FRAME_MODE constants STREAM=0, FRAME=1.
REQ-029 Storage SHALL be sub-module eth_sdp_ram (simple dual-port, one-cycle registered read, parameters width and address width); all control in eth_frame_fifo.

Verification (DATA_WIDTH=8, DEPTH_WIDTH=4 unless noted)
REQ-030 FRAME_MODE=0, write 0x01..0x10 back-to-back, rd_en=0 -> wr_vld=0 after 16th, level=16; then rd_en=1 -> 0x01..0x10 in order, one per clock, rd_vld falls after 0x10.
REQ-031 FRAME_MODE=1, 5-beat frame 0xA0..0xA4, rd_en=1 -> rd_vld stays 0 until 2 edges after wr_last; then 0xA0..0xA4, rd_last=1 only on 0xA4; frame_cnt 1->0.
REQ-032 FRAME_MODE=1, 4-beat frame with wr_err=1 on last, then 3-beat good frame 0x30..0x32 -> drop_cnt=1, reader sees only 0x30..0x32.
REQ-033 FRAME_MODE=1, 10-beat committed frame unread, then 8-beat frame -> overflow at beat 7, DROP, drop_cnt=1, level=10, first frame reads intact.
REQ-034 rst_n low for one cycle mid-frame after 3 beats, level=6 -> all outputs zero per REQ-026, drop_cnt=0, next frame commits normally.

Source files
------------

// File: rtl/eth_fifo_pkg.sv
// Shared constants and write-side state encoding for the Ethernet frame FIFO.
package eth_fifo_pkg;

  localparam int unsigned STREAM = 0;
  localparam int unsigned FRAME  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module eth_sdp_ram #(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; storage is not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_frame_fifo.sv
// Store-and-forward (or plain streaming) FIFO with a first-word-fall-through
// read side. Frames are written speculatively and only become visible to the
// reader once their last beat commits without error.
module eth_frame_fifo
  import eth_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH_WIDTH    = 11,
  parameter int unsigned FRAME_MODE     = FRAME,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_last,
  input  logic                      wr_err,
  output logic                      wr_vld,
  input  logic                      rd_en,
  output logic                      rd_vld,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic [DEPTH_WIDTH:0]      level,
  output logic [DEPTH_WIDTH:0]      frame_cnt,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned AW = DEPTH_WIDTH;
  localparam int unsigned PW = DEPTH_WIDTH + 1;
  localparam int unsigned MW = DATA_WIDTH + 1;

  localparam logic [PW-1:0]             PTR_INC  = PW'(1);
  localparam logic [AW-1:0]             ADDR_INC = AW'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_INC = DROP_CNT_WIDTH'(1);

  wr_state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;   // speculative write pointer
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;   // committed (reader-visible) pointer
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;   // oldest unpopped word
  logic [PW-1:0] fe_ptr_q, fe_ptr_d;   // next word to fetch from RAM

  logic                      ram_vld_q, ram_vld_d;
  logic                      out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic [PW-1:0]             frame_cnt_q, frame_cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic          full;
  logic          ram_we, commit, drop, rewind, advance;
  logic          pop, out_free, s1_move, s1_free, issue, frame_inc, frame_dec;
  logic [AW-1:0] fe_addr, raddr;
  logic [MW-1:0] ram_rdata;

  assign full = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  eth_sdp_ram #(
    .WIDTH      (MW),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({wr_last, wr_data}),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM next state; a full-FIFO beat that is itself the last beat
  // ends the frame immediately instead of parking in DROP.
  always_comb begin
    state_d = state_q;
    if (FRAME_MODE == FRAME && wr_en) begin
      case (state_q)
        ST_IDLE, ST_FILL: state_d = wr_last ? ST_IDLE : (full ? ST_DROP : ST_FILL);
        ST_DROP:          state_d = wr_last ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Write FSM outputs: store, commit, drop and rewind strobes.
  always_comb begin
    ram_we  = 1'b0;
    advance = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    rewind  = 1'b0;
    if (FRAME_MODE == STREAM) begin
      if (wr_en && !full) begin
        ram_we  = 1'b1;
        advance = 1'b1;
        commit  = 1'b1;
      end
    end else if (wr_en) begin
      case (state_q)
        ST_IDLE, ST_FILL: begin
          if (full) begin
            rewind = 1'b1;
            drop   = wr_last;
          end else begin
            ram_we  = 1'b1;
            advance = 1'b1;
            if (wr_last) begin
              if (wr_err) begin
                rewind = 1'b1;
                drop   = 1'b1;
              end else begin
                commit = 1'b1;
              end
            end
          end
        end
        ST_DROP: drop = wr_last;
        default: ;
      endcase
    end
  end

  // Pointers, counters and the two-stage prefetch (RAM read reg -> output reg).
  // While the RAM stage is stalled its address is re-read each cycle so the
  // held word survives the always-loading RAM read register.
  always_comb begin
    pop       = rd_en && out_vld_q;
    out_free  = !out_vld_q || pop;
    s1_move   = ram_vld_q && out_free;
    s1_free   = !ram_vld_q || s1_move;
    issue     = s1_free && (fe_ptr_q != cm_ptr_q);
    fe_addr   = fe_ptr_q[AW-1:0];
    raddr     = issue ? fe_addr : fe_addr - ADDR_INC;
    frame_inc = commit && wr_last;
    frame_dec = pop && out_last_q;

    wr_ptr_d = wr_ptr_q;
    if (rewind) begin
      wr_ptr_d = cm_ptr_q;
    end else if (advance) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end
    cm_ptr_d  = commit ? wr_ptr_q + PTR_INC : cm_ptr_q;
    rd_ptr_d  = pop    ? rd_ptr_q + PTR_INC : rd_ptr_q;
    fe_ptr_d  = issue  ? fe_ptr_q + PTR_INC : fe_ptr_q;
    ram_vld_d = issue || (ram_vld_q && !s1_move);

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (s1_move) begin
      out_vld_d  = 1'b1;
      out_data_d = ram_rdata[DATA_WIDTH-1:0];
      out_last_d = ram_rdata[MW-1];
    end else if (pop) begin
      out_vld_d = 1'b0;
    end

    frame_cnt_d = frame_cnt_q;
    if (frame_inc && !frame_dec) begin
      frame_cnt_d = frame_cnt_q + PTR_INC;
    end else if (frame_dec && !frame_inc) begin
      frame_cnt_d = frame_cnt_q - PTR_INC;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + DROP_INC;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fe_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fe_ptr_q    <= fe_ptr_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign wr_vld    = (FRAME_MODE == FRAME) ? 1'b1 : !full;
  assign rd_vld    = out_vld_q;
  assign rd_data   = out_data_q;
  assign rd_last   = out_last_q;
  assign level     = cm_ptr_q - rd_ptr_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_fifo.sv
// Directed bench for eth_frame_fifo: one streaming instance and one frame
// instance (narrow drop counter so saturation is reachable).
module tb_eth_frame_fifo;
  import eth_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       s_wr_en = 0, s_wr_last = 0, s_wr_err = 0, s_rd_en = 0;
  logic [7:0] s_wr_data = '0;
  logic       s_wr_vld, s_rd_vld, s_rd_last;
  logic [7:0] s_rd_data;
  logic [4:0] s_level, s_frame_cnt;
  logic [15:0] s_drop_cnt;

  logic       f_wr_en = 0, f_wr_last = 0, f_wr_err = 0, f_rd_en = 0;
  logic [7:0] f_wr_data = '0;
  logic       f_wr_vld, f_rd_vld, f_rd_last;
  logic [7:0] f_rd_data;
  logic [4:0] f_level, f_frame_cnt;
  logic [1:0] f_drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  eth_frame_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FRAME_MODE(STREAM), .DROP_CNT_WIDTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_last(s_wr_last),
    .wr_err(s_wr_err), .wr_vld(s_wr_vld), .rd_en(s_rd_en), .rd_vld(s_rd_vld),
    .rd_data(s_rd_data), .rd_last(s_rd_last), .level(s_level), .frame_cnt(s_frame_cnt),
    .drop_cnt(s_drop_cnt));

  eth_frame_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FRAME_MODE(FRAME), .DROP_CNT_WIDTH(2)) dut_f (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_last(f_wr_last),
    .wr_err(f_wr_err), .wr_vld(f_wr_vld), .rd_en(f_rd_en), .rd_vld(f_rd_vld),
    .rd_data(f_rd_data), .rd_last(f_rd_last), .level(f_level), .frame_cnt(f_frame_cnt),
    .drop_cnt(f_drop_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One beat on the frame instance, taken at the next edge.
  task automatic f_beat(input logic [7:0] d, input logic last, input logic err);
    f_wr_en = 1'b1; f_wr_data = d; f_wr_last = last; f_wr_err = err;
    tick();
    f_wr_en = 1'b0; f_wr_last = 1'b0; f_wr_err = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({s_rd_vld, s_rd_data, s_rd_last, s_level, s_frame_cnt, s_drop_cnt, s_wr_vld} !== 37'h1) begin
      miscompares++;
      $display("FAIL reset_stream: got %h want %h",
               {s_rd_vld, s_rd_data, s_rd_last, s_level, s_frame_cnt, s_drop_cnt, s_wr_vld}, 37'h1);
    end
    vectors++;
    if ({f_rd_vld, f_rd_data, f_rd_last, f_level, f_frame_cnt, f_drop_cnt, f_wr_vld} !== 23'h1) begin
      miscompares++;
      $display("FAIL reset_frame: got %h want %h",
               {f_rd_vld, f_rd_data, f_rd_last, f_level, f_frame_cnt, f_drop_cnt, f_wr_vld}, 23'h1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({s_rd_vld, s_level, s_wr_vld} !== 7'h01) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", {s_rd_vld, s_level, s_wr_vld}, 7'h01);
    end
  endtask

  task automatic test_stream_fill_drain();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = 8'(i + 1); s_wr_last = (i == 15);
      tick();
      vectors++;
      if (s_rd_vld !== (i >= 2)) begin
        miscompares++;
        $display("FAIL stream_rd_vld_latency[%0d]: got %b want %b", i, s_rd_vld, (i >= 2));
      end
    end
    s_wr_last = 1'b0;
    vectors++;
    if ({s_wr_vld, s_level} !== {1'b0, 5'd16}) begin
      miscompares++;
      $display("FAIL stream_full: got wr_vld=%b level=%0d want 0/16", s_wr_vld, s_level);
    end
    // Offered beat while full must be refused.
    s_wr_data = 8'hEE;
    tick();
    s_wr_en = 1'b0;
    vectors++;
    if (s_level !== 5'd16) begin
      miscompares++;
      $display("FAIL stream_full_refuse: got level=%0d want 16", s_level);
    end
    s_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, (i == 15), 8'(i + 1)};
      vectors++;
      if ({s_rd_vld, s_rd_last, s_rd_data} !== exp) begin
        miscompares++;
        $display("FAIL stream_drain[%0d]: got %h want %h", i, {s_rd_vld, s_rd_last, s_rd_data}, exp);
      end
      tick();
    end
    s_rd_en = 1'b0;
    vectors++;
    if ({s_rd_vld, s_level, s_wr_vld} !== 7'h01) begin
      miscompares++;
      $display("FAIL stream_empty: got %h want %h", {s_rd_vld, s_level, s_wr_vld}, 7'h01);
    end
  endtask

  task automatic test_frame_good();
    logic [9:0] exp;
    do_reset();
    f_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_beat(8'(8'hA0 + i), (i == 4), 1'b0);
      vectors++;
      if (f_rd_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_hidden[%0d]: got rd_vld=%b want 0", i, f_rd_vld);
      end
    end
    vectors++;
    if (f_frame_cnt !== 5'd1) begin
      miscompares++;
      $display("FAIL frame_cnt_commit: got %0d want 1", f_frame_cnt);
    end
    tick();
    vectors++;
    if (f_rd_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_first_edge: got rd_vld=%b want 0", f_rd_vld);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = {1'b1, (k == 4), 8'(8'hA0 + k)};
      vectors++;
      if ({f_rd_vld, f_rd_last, f_rd_data} !== exp || f_frame_cnt !== 5'd1) begin
        miscompares++;
        $display("FAIL frame_read[%0d]: got %h cnt=%0d want %h cnt=1", k,
                 {f_rd_vld, f_rd_last, f_rd_data}, f_frame_cnt, exp);
      end
      tick();
    end
    f_rd_en = 1'b0;
    vectors++;
    if ({f_rd_vld, f_frame_cnt, f_level} !== 11'h0) begin
      miscompares++;
      $display("FAIL frame_done: got %h want %h", {f_rd_vld, f_frame_cnt, f_level}, 11'h0);
    end
  endtask

  task automatic test_drop_bad();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) f_beat(8'(8'h20 + i), (i == 3), (i == 3));
    vectors++;
    if ({f_drop_cnt, f_level, f_frame_cnt, f_rd_vld} !== {2'd1, 5'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL bad_frame_drop: got drop=%0d level=%0d frames=%0d vld=%b want 1/0/0/0",
               f_drop_cnt, f_level, f_frame_cnt, f_rd_vld);
    end
    for (int i = 0; i < 3; i++) f_beat(8'(8'h30 + i), (i == 2), 1'b0);
    vectors++;
    if ({f_level, f_frame_cnt} !== {5'd3, 5'd1}) begin
      miscompares++;
      $display("FAIL good_after_bad: got level=%0d frames=%0d want 3/1", f_level, f_frame_cnt);
    end
    tick();
    tick();
    f_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = {1'b1, (k == 2), 8'(8'h30 + k)};
      vectors++;
      if ({f_rd_vld, f_rd_last, f_rd_data} !== exp) begin
        miscompares++;
        $display("FAIL good_after_bad_read[%0d]: got %h want %h", k, {f_rd_vld, f_rd_last, f_rd_data}, exp);
      end
      tick();
    end
    f_rd_en = 1'b0;
    vectors++;
    if ({f_rd_vld, f_drop_cnt} !== 3'b001) begin
      miscompares++;
      $display("FAIL bad_frame_end: got vld=%b drop=%0d want 0/1", f_rd_vld, f_drop_cnt);
    end
  endtask

  task automatic test_commit_pop_overlap();
    do_reset();
    f_beat(8'hC0, 1'b1, 1'b0);
    tick();
    tick();
    vectors++;
    if ({f_rd_vld, f_rd_last, f_rd_data, f_frame_cnt} !== {1'b1, 1'b1, 8'hC0, 5'd1}) begin
      miscompares++;
      $display("FAIL single_beat_frame: got %h want %h",
               {f_rd_vld, f_rd_last, f_rd_data, f_frame_cnt}, {1'b1, 1'b1, 8'hC0, 5'd1});
    end
    f_rd_en = 1'b1;
    f_beat(8'hC1, 1'b1, 1'b0);
    f_rd_en = 1'b0;
    vectors++;
    if ({f_frame_cnt, f_level, f_rd_vld} !== {5'd1, 5'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL overlap_net: got frames=%0d level=%0d vld=%b want 1/1/0",
               f_frame_cnt, f_level, f_rd_vld);
    end
    tick();
    tick();
    vectors++;
    if ({f_rd_vld, f_rd_last, f_rd_data} !== {1'b1, 1'b1, 8'hC1}) begin
      miscompares++;
      $display("FAIL overlap_next: got %h want %h", {f_rd_vld, f_rd_last, f_rd_data}, {1'b1, 1'b1, 8'hC1});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int idx;
    do_reset();
    idx = 0;
    f_rd_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c < 5) begin
        f_wr_en = 1'b1; f_wr_data = 8'(8'h11 + c); f_wr_last = (c == 2 || c == 4);
      end else begin
        f_wr_en = 1'b0; f_wr_last = 1'b0;
      end
      if (f_rd_vld) begin
        exp = {(idx == 2 || idx == 4), 8'(8'h11 + idx)};
        vectors++;
        if (idx >= 5 || {f_rd_last, f_rd_data} !== exp) begin
          miscompares++;
          $display("FAIL b2b_read[%0d]: got %h want %h", idx, {f_rd_last, f_rd_data}, exp);
        end
        idx++;
      end
      tick();
    end
    f_rd_en = 1'b0;
    vectors++;
    if (idx != 5 || f_frame_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL b2b_count: got words=%0d frames=%0d want 5/0", idx, f_frame_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) f_beat(8'(8'h40 + i), (i == 9), 1'b0);
    vectors++;
    if ({f_level, f_frame_cnt} !== {5'd10, 5'd1}) begin
      miscompares++;
      $display("FAIL ovf_first: got level=%0d frames=%0d want 10/1", f_level, f_frame_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      f_beat(8'(8'h50 + i), (i == 7), 1'b0);
      vectors++;
      if (f_wr_vld !== 1'b1 || f_level !== 5'd10) begin
        miscompares++;
        $display("FAIL ovf_beat[%0d]: got wr_vld=%b level=%0d want 1/10", i, f_wr_vld, f_level);
      end
    end
    vectors++;
    if ({f_drop_cnt, f_frame_cnt} !== {2'd1, 5'd1}) begin
      miscompares++;
      $display("FAIL ovf_drop: got drop=%0d frames=%0d want 1/1", f_drop_cnt, f_frame_cnt);
    end
    f_rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp = {1'b1, (k == 9), 8'(8'h40 + k)};
      vectors++;
      if ({f_rd_vld, f_rd_last, f_rd_data} !== exp) begin
        miscompares++;
        $display("FAIL ovf_read[%0d]: got %h want %h", k, {f_rd_vld, f_rd_last, f_rd_data}, exp);
      end
      tick();
    end
    f_rd_en = 1'b0;
    vectors++;
    if ({f_rd_vld, f_level, f_frame_cnt} !== 11'h0) begin
      miscompares++;
      $display("FAIL ovf_empty: got %h want %h", {f_rd_vld, f_level, f_frame_cnt}, 11'h0);
    end
    f_beat(8'h60, 1'b0, 1'b0);
    f_beat(8'h61, 1'b1, 1'b0);
    vectors++;
    if (f_level !== 5'd2) begin
      miscompares++;
      $display("FAIL ovf_rewind_level: got %0d want 2", f_level);
    end
    tick();
    tick();
    f_rd_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp = {1'b1, (k == 1), 8'(8'h60 + k)};
      vectors++;
      if ({f_rd_vld, f_rd_last, f_rd_data} !== exp) begin
        miscompares++;
        $display("FAIL ovf_rewind_read[%0d]: got %h want %h", k, {f_rd_vld, f_rd_last, f_rd_data}, exp);
      end
      tick();
    end
    f_rd_en = 1'b0;
  endtask

  task automatic test_drop_saturate();
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f_beat(8'hE0, 1'b1, 1'b1);
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      vectors++;
      if (f_drop_cnt !== exp) begin
        miscompares++;
        $display("FAIL drop_sat[%0d]: got %0d want %0d", i, f_drop_cnt, exp);
      end
    end
    vectors++;
    if (f_level !== 5'd0) begin
      miscompares++;
      $display("FAIL drop_sat_level: got %0d want 0", f_level);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) f_beat(8'(8'h70 + i), (i == 5), 1'b0);
    tick();
    tick();
    vectors++;
    if ({f_level, f_rd_vld, f_rd_data} !== {5'd6, 1'b1, 8'h70}) begin
      miscompares++;
      $display("FAIL mid_pre: got level=%0d vld=%b data=%h want 6/1/70", f_level, f_rd_vld, f_rd_data);
    end
    for (int i = 0; i < 3; i++) f_beat(8'(8'h80 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({f_rd_vld, f_rd_data, f_rd_last, f_level, f_frame_cnt, f_drop_cnt, f_wr_vld} !== 23'h1) begin
      miscompares++;
      $display("FAIL mid_reset: got %h want %h",
               {f_rd_vld, f_rd_data, f_rd_last, f_level, f_frame_cnt, f_drop_cnt, f_wr_vld}, 23'h1);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) f_beat(8'(8'h90 + i), (i == 2), 1'b0);
    vectors++;
    if ({f_frame_cnt, f_level, f_drop_cnt} !== {5'd1, 5'd3, 2'd0}) begin
      miscompares++;
      $display("FAIL mid_after: got frames=%0d level=%0d drop=%0d want 1/3/0",
               f_frame_cnt, f_level, f_drop_cnt);
    end
    tick();
    tick();
    f_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = {1'b1, (k == 2), 8'(8'h90 + k)};
      vectors++;
      if ({f_rd_vld, f_rd_last, f_rd_data} !== exp) begin
        miscompares++;
        $display("FAIL mid_read[%0d]: got %h want %h", k, {f_rd_vld, f_rd_last, f_rd_data}, exp);
      end
      tick();
    end
    f_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream_fill_drain();
    test_frame_good();
    test_drop_bad();
    test_commit_pop_overlap();
    test_back_to_back();
    test_overflow();
    test_drop_saturate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
